// File: rtl/intan_peripheral_emulator.sv
// RHD2000 headstage SPI peripheral model: COPI command capture, two-frame-delayed CIPO.
// Define INTAN_EMU_DDR_EN for the dual-die (RHD2164-style) DDR CIPO variant.
module intan_peripheral_emulator #(
   parameter logic [7:0] CHIP_ID     = 8'd1,
   parameter logic [7:0] DIE_REV     = 8'd0,
   parameter int         NUM_RW_REGS = 18
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        csn,
   input  logic        sclk,
   input  logic        copi,
   output logic        cipo,
   output logic [31:0] frames_rcvd,
   output logic [15:0] frame_errors,
   output logic [15:0] last_cmd
);

`ifdef INTAN_EMU_DDR_EN
   localparam int TXW = 32;
`else
   localparam int TXW = 16;
`endif
   localparam int AW = (NUM_RW_REGS > 1) ? $clog2(NUM_RW_REGS) : 1;
   localparam logic [6:0] NRW = 7'(NUM_RW_REGS);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t state, state_nx;

   logic [1:0] csn_q, sclk_q, copi_q;
   logic       csn_d, sclk_d;
   logic [1:0] warm;
   logic       armed;

   logic csn_fall, csn_rise, sclk_rise, sclk_fall, start;
   logic load, rx_en, tx_en, good, bad;

   logic [15:0]    rx_shift;
   logic [4:0]     rx_bits;
   logic [TXW-1:0] tx, tx_init;
   logic [15:0]    slot0, slot1, result;
   logic [9:0]     conv;
   logic [7:0]     regs [NUM_RW_REGS];
   logic [7:0]     rd_val;
   logic [5:0]     addr;
   logic [7:0]     dat;
   logic           addr_rw;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         csn_q  <= 2'b11;
         sclk_q <= 2'b00;
         copi_q <= 2'b00;
         csn_d  <= 1'b1;
         sclk_d <= 1'b0;
      end else begin
         csn_q  <= {csn_q[0], csn};
         sclk_q <= {sclk_q[0], sclk};
         copi_q <= {copi_q[0], copi};
         csn_d  <= csn_q[1];
         sclk_d <= sclk_q[1];
      end
   end

   assign csn_fall  = csn_d & ~csn_q[1];
   assign csn_rise  = ~csn_d & csn_q[1];
   assign sclk_rise = ~sclk_d & sclk_q[1];
   assign sclk_fall = sclk_d & ~sclk_q[1];

   // A frame already open when reset releases must not be mistaken for a new one:
   // only arm once the synchronized CSn has been seen high.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         warm  <= 2'd0;
         armed <= 1'b0;
      end else begin
         if (warm != 2'd3) warm <= warm + 2'd1;
         if (warm[1] && csn_q[1]) armed <= 1'b1;
      end
   end

   assign start = csn_fall & armed;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (csn_rise) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load  = (state == IDLE) & start;
      rx_en = (state == SHIFT) & sclk_rise;
`ifdef INTAN_EMU_DDR_EN
      tx_en = (state == SHIFT) & (sclk_rise | sclk_fall);
`else
      tx_en = (state == SHIFT) & sclk_fall;
`endif
      good  = (state == FINISH) & (rx_bits == 5'd16);
      bad   = (state == FINISH) & (rx_bits != 5'd16);
   end

   always_comb begin
      tx_init = '0;
`ifdef INTAN_EMU_DDR_EN
      for (int i = 0; i < 16; i++) begin
         tx_init[2*i+1] = slot0[i];
         tx_init[2*i]   = (i == 15) ? ~slot0[i] : slot0[i];
      end
`else
      tx_init = slot0;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_shift <= '0;
         rx_bits  <= '0;
         tx       <= '0;
         cipo     <= 1'b0;
      end else if (load) begin
         rx_bits <= '0;
         tx      <= tx_init;
         cipo    <= tx_init[TXW-1];
      end else if (state == SHIFT) begin
         if (rx_en) begin
            rx_shift <= {rx_shift[14:0], copi_q[1]};
            if (rx_bits != 5'd17) rx_bits <= rx_bits + 5'd1;
         end
         if (tx_en) begin
            tx   <= tx << 1;
            cipo <= tx[TXW-2];
         end
      end else begin
         cipo <= 1'b0;
      end
   end

   assign addr    = rx_shift[13:8];
   assign dat     = rx_shift[7:0];
   assign addr_rw = ({1'b0, addr} < NRW);

   always_comb begin
      rd_val = 8'h00;
      unique case (1'b1)
         addr_rw:       rd_val = regs[addr[AW-1:0]];
         (addr == 6'd40): rd_val = 8'h49;
         (addr == 6'd41): rd_val = 8'h4E;
         (addr == 6'd42): rd_val = 8'h54;
         (addr == 6'd43): rd_val = 8'h41;
         (addr == 6'd44): rd_val = 8'h4E;
         (addr == 6'd60): rd_val = DIE_REV;
         (addr == 6'd63): rd_val = CHIP_ID;
         default:       rd_val = 8'h00;
      endcase
   end

   always_comb begin
      result = 16'h0000;
      unique case (rx_shift[15:14])
         2'b00:   result = {addr, conv};
         2'b01:   result = 16'h0000;
         2'b10:   result = {8'hFF, dat};
         2'b11:   result = {8'h00, rd_val};
         default: result = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot0        <= '0;
         slot1        <= '0;
         conv         <= '0;
         frames_rcvd  <= '0;
         frame_errors <= '0;
         last_cmd     <= '0;
      end else begin
         if (good) begin
            slot0       <= slot1;
            slot1       <= result;
            frames_rcvd <= frames_rcvd + 32'd1;
            last_cmd    <= rx_shift;
            if (rx_shift[15:14] == 2'b00) conv <= conv + 10'd1;
         end
         if (bad && frame_errors != 16'hFFFF)
            frame_errors <= frame_errors + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_RW_REGS; i++) regs[i] <= 8'h00;
      end else if (good && rx_shift[15:14] == 2'b10 && addr_rw) begin
         regs[addr[AW-1:0]] <= dat;
      end
   end

endmodule

// File: tb/tb_intan_peripheral_emulator.sv
// Bench for intan_peripheral_emulator: directed frames plus random commands
// checked against a command-level model of the RHD register/pipeline behaviour.
module tb_intan_peripheral_emulator;

   localparam int         H    = 8;
   localparam int         NRW  = 18;
   localparam logic [7:0] CHIP = 8'h12;
   localparam logic [7:0] DIE  = 8'h03;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        csn = 1'b1;
   logic        sclk = 1'b0;
   logic        copi = 1'b0;
   logic        cipo;
   logic [31:0] frames_rcvd;
   logic [15:0] frame_errors;
   logic [15:0] last_cmd;

   intan_peripheral_emulator #(
      .CHIP_ID(CHIP),
      .DIE_REV(DIE),
      .NUM_RW_REGS(NRW)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .csn(csn),
      .sclk(sclk),
      .copi(copi),
      .cipo(cipo),
      .frames_rcvd(frames_rcvd),
      .frame_errors(frame_errors),
      .last_cmd(last_cmd)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   logic [7:0]  m_regs [NRW];
   logic [9:0]  m_conv;
   logic [15:0] m_s0, m_s1, m_last;
   int          m_frames, m_errs;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NRW; i++) m_regs[i] = 8'h00;
      m_conv = '0;
      m_s0 = '0;
      m_s1 = '0;
      m_last = '0;
      m_frames = 0;
      m_errs = 0;
   endtask

   function automatic logic [7:0] m_read(input int r);
      if (r < NRW) return m_regs[r];
      case (r)
         40: return 8'h49;
         41: return 8'h4E;
         42: return 8'h54;
         43: return 8'h41;
         44: return 8'h4E;
         60: return DIE;
         63: return CHIP;
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_exec(input logic [15:0] cmd, output logic [15:0] res);
      int r;
      r = int'(cmd[13:8]);
      case (cmd[15:14])
         2'b00: begin res = {cmd[13:8], m_conv}; m_conv = m_conv + 10'd1; end
         2'b01: res = 16'h0000;
         2'b10: begin
            res = {8'hFF, cmd[7:0]};
            if (r < NRW) m_regs[r] = cmd[7:0];
         end
         default: res = {8'h00, m_read(r)};
      endcase
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      csn = 1'b1;
      sclk = 1'b0;
      copi = 1'b0;
      tick(4);
      rstn = 1'b1;
      model_reset();
      tick(4);
   endtask

   task automatic frame(input logic [15:0] cmd, input int nbits,
                        output logic [15:0] rsp);
      logic [15:0] exp_a, a, b, res;
      logic [31:0] samp;
      exp_a = m_s0;
      samp = '0;
      csn = 1'b0;
      tick(H);
      for (int i = 0; i < nbits; i++) begin
         copi = (i < 16) ? cmd[15-i] : 1'b0;
         tick(H);
         if (i < 16) samp[31-2*i] = cipo;
         sclk = 1'b1;
         tick(H);
         if (i < 16) samp[30-2*i] = cipo;
         sclk = 1'b0;
      end
      tick(H);
      csn = 1'b1;
      tick(8);
      for (int i = 0; i < 16; i++) begin
         a[15-i] = samp[31-2*i];
         b[15-i] = samp[30-2*i];
      end
`ifdef INTAN_EMU_DDR_EN
      rsp = a;
      if (nbits == 16) begin
         check("cipo_die_a", {16'h0, a}, {16'h0, exp_a});
         check("cipo_die_b", {16'h0, b}, {16'h0, exp_a ^ 16'h8000});
      end
`else
      rsp = b;
      if (nbits == 16) check("cipo_word", {16'h0, b}, {16'h0, exp_a});
`endif
      if (nbits == 16) begin
         m_exec(cmd, res);
         m_s0 = m_s1;
         m_s1 = res;
         m_frames++;
         m_last = cmd;
      end else if (m_errs < 65535) begin
         m_errs++;
      end
      check("frames_rcvd", frames_rcvd, m_frames);
      check("frame_errors", {16'h0, frame_errors}, m_errs);
      check("last_cmd", {16'h0, last_cmd}, {16'h0, m_last});
   endtask

   logic [15:0] rsp, cmd;
   logic [5:0]  ra;
   int          nb;

   initial begin
      model_reset();
      tick(3);
      check("rst_cipo", {31'h0, cipo}, 32'h0);
      check("rst_frames", frames_rcvd, 32'h0);
      check("rst_errors", {16'h0, frame_errors}, 32'h0);
      check("rst_last", {16'h0, last_cmd}, 32'h0);
      do_reset();

      frame(16'hE800, 16, rsp);
      frame(16'hE900, 16, rsp);
      frame(16'hEA00, 16, rsp);
      check("rom_I", {16'h0, rsp}, 32'h0049);
      frame(16'hEB00, 16, rsp);
      check("rom_N", {16'h0, rsp}, 32'h004E);
      check("rom_frames", frames_rcvd, 32'd4);

      do_reset();
      frame(16'h85A7, 16, rsp);
      frame(16'hC500, 16, rsp);
      frame(16'h0000, 16, rsp);
      check("wr_echo", {16'h0, rsp}, 32'hFFA7);
      frame(16'h0000, 16, rsp);
      check("rd_back", {16'h0, rsp}, 32'h00A7);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         frame(16'h0700, 16, rsp);
         if (i >= 2)
            check("conv_ch7", {16'h0, rsp}, 32'h1C00 + 32'(i - 2));
      end

      frame(16'hE800, 9, rsp);
      check("bad_errors", {16'h0, frame_errors}, 32'd1);
      frame(16'h0700, 16, rsp);
      check("bad_skip", {16'h0, rsp}, 32'h1C03);

      frame(16'h825A, 16, rsp);
      frame(16'hC200, 16, rsp);
      csn = 1'b0;
      tick(H);
      cmd = 16'h8233;
      for (int i = 0; i < 16; i++) begin
         copi = cmd[15-i];
         tick(H);
         sclk = 1'b1;
         if (i == 7) begin
            tick(2);
            rstn = 1'b0;
            #1;
            check("midrst_cipo", {31'h0, cipo}, 32'h0);
            check("midrst_frames", frames_rcvd, 32'h0);
            model_reset();
            tick(3);
            rstn = 1'b1;
         end
         tick(H);
         sclk = 1'b0;
      end
      tick(H);
      csn = 1'b1;
      tick(8);
      check("postrst_frames", frames_rcvd, m_frames);
      check("postrst_errors", {16'h0, frame_errors}, m_errs);
      frame(16'hC200, 16, rsp);
      frame(16'h0000, 16, rsp);
      frame(16'h0000, 16, rsp);
      check("postrst_reg2", {16'h0, rsp}, 32'h0000);

      frame(16'hFF00, 16, rsp);
      frame(16'hFC00, 16, rsp);
      frame(16'h5500, 16, rsp);
      check("chip_id", {16'h0, rsp}, 32'h0012);
      frame(16'h6A00, 16, rsp);
      check("die_rev", {16'h0, rsp}, 32'h0003);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0: cmd = {2'b00, 6'($urandom_range(0, 63)), 8'($urandom)};
            1: cmd = ($urandom_range(0, 1) != 0) ? 16'h5500 : 16'h6A00;
            2: cmd = {2'b01, 14'($urandom)};
            3: cmd = {2'b10, 6'($urandom_range(0, 24)), 8'($urandom)};
            default: begin
               case ($urandom_range(0, 7))
                  0, 1, 2: ra = 6'($urandom_range(0, NRW - 1));
                  3: ra = 6'(40 + $urandom_range(0, 4));
                  4: ra = 6'd60;
                  5: ra = 6'd63;
                  default: ra = 6'($urandom_range(0, 63));
               endcase
               cmd = {2'b11, ra, 8'($urandom)};
            end
         endcase
         nb = 16;
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
               0: nb = 9;
               1: nb = 15;
               default: nb = 17;
            endcase
         end
         frame(cmd, nb, rsp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/intan_peripheral_emulator.md
Name: intan_peripheral_emulator

Overview:
- PL-side model of an RHD2000-series headstage (SPI peripheral end of the CSn/SCLK/COPI/CIPO link).
- Captures 16-bit COPI commands and drives CIPO with the RHD two-frame-delayed response.
- Used for on-board loopback of the acquisition core without a headstage, and as the bench peripheral for that core.
- CIPO is routed back to the core's cipo0/cipo1 input through a board-level or fabric mux outside this block.

Parameters:
- CHIP_ID, 8'd1, value returned for ROM register 63.
- DIE_REV, 8'd0, value returned for ROM register 60.
- NUM_RW_REGS, 18, number of writable registers (0..NUM_RW_REGS-1); max 32.

Ports:
- clk  in  1  system clock; same clock as the acquisition core, 4x SCLK rate.
- rstn  in  1  asynchronous active-low reset.
- csn  in  1  chip select from controller, active low; asynchronous to this block.
- sclk  in  1  serial clock from controller.
- copi  in  1  command data, MSB first, sampled on SCLK rising edge.
- cipo  out  1  response data, MSB first.
- frames_rcvd  out  32  count of well-formed frames.
- frame_errors  out  16  count of malformed frames; saturates at 16'hFFFF.
- last_cmd  out  16  most recent well-formed command word.

Behaviour:
- Reset values: cipo=0, frames_rcvd=0, frame_errors=0, last_cmd=0.
  - Also cleared: synchronizers to idle (csn=1, sclk=0), both response pipeline slots=16'h0000, conv_count=0, all RW registers=8'h00.
- Input conditioning:
  - csn, sclk and copi each pass through a 2-FF synchronizer.
  - Edges are detected on the synchronized signals, giving 3 clk latency from pin to detected edge.
  - copi is captured from the synchronized copi in the same clk that the SCLK rising edge is detected.
- FSM states IDLE, SHIFT, FINISH:
  - IDLE -> SHIFT on CSn falling edge:
    - rx_bits cleared to 0.
    - tx shift register loaded with pipeline slot 0.
    - cipo driven with tx[15] on the next clk.
  - SHIFT, SCLK rising edge:
    - rx_shift <= {rx_shift[14:0], copi_sync}.
    - rx_bits increments, saturating at 17.
  - SHIFT, SCLK falling edge: tx shifts left; cipo <= next bit (tx[14] after the first falling edge, and so on). After 16 falling edges cipo holds 0.
  - SHIFT -> FINISH on CSn rising edge.
  - FINISH, one clk, then -> IDLE:
    - If rx_bits==16: decode rx_shift, push the result into the pipeline, frames_rcvd+1, last_cmd<=rx_shift.
    - Otherwise: frame_errors+1 (saturating); no decode and no pipeline advance.
    - cipo=0 in FINISH and IDLE.
  - CSn rising edge and SCLK edge detected in the same clk: the SCLK edge is processed first, then the transition to FINISH.
- Response pipeline (RHD semantics: frame N returns the result of command N-2):
  - Two slots; on push, slot0<=slot1 and slot1<=new_result.
  - cmd[15:14]=00, CONVERT(ch=cmd[13:8]): result={ch, conv_count[9:0]}; conv_count+1 (10-bit wrap).
  - cmd=16'h5500 (CALIBRATE) or 16'h6A00 (CLEAR): result=16'h0000.
  - Any other cmd[15:14]=01: result=16'h0000; counted as a well-formed frame.
  - cmd[15:14]=10, WRITE(reg=cmd[13:8], data=cmd[7:0]):
    - If reg<NUM_RW_REGS, reg<=data.
    - result={8'hFF, data} regardless of whether reg is writable.
  - cmd[15:14]=11, READ(reg=cmd[13:8]): result={8'h00, val}, where val is:
    - reg<NUM_RW_REGS: stored value.
    - 40..44: 'I','N','T','A','N' (8'h49,4E,54,41,4E).
    - 60: DIE_REV.
    - 63: CHIP_ID.
    - otherwise: 8'h00.
  - READ of a register written in the immediately preceding frame returns the new value.
- rstn asserted mid-frame: all state clears asynchronously and cipo=0. After release, the first CSn falling edge starts a fresh frame; a frame already in progress at release is not captured.

Optional Feature:
- Macro INTAN_EMU_DDR_EN.
- Defined: emulates a dual-die (RHD2164-style) part with DDR CIPO.
  - tx is 32 bits, interleaved A15,B15,A14,B14,...,A0,B0.
  - cipo advances on both detected SCLK edges: the first bit is presented at CSn fall, and each SCLK edge then presents the next bit, giving 32 bits per frame.
  - Die B result = die A result XOR 16'h8000.
  - Both dies share registers and conv_count.
- Undefined: single 16-bit word, advanced on SCLK falling edges only; no die B logic.

Test Plan:
- Reset, then frames READ 40, READ 41, READ 42, READ 43 (16'hE800, E900, EA00, EB00) -> frames 3 and 4 return 16'h0049 and 16'h004E; frames_rcvd=4.
- WRITE reg 5 = 8'hA7 (16'h85A7), READ 5 (16'hC500), 2 dummy CONVERTs -> 3rd frame cipo=16'hFFA7, 4th frame cipo=16'h00A7.
- 3 frames CONVERT ch 7 (16'h0700) then 2 more -> frames 3..5 return 16'h1C00, 16'h1C01, 16'h1C02.
- CSn pulsed low with only 9 SCLK cycles -> frame_errors=1, frames_rcvd unchanged, next valid frame returns the same slot as if the bad frame never occurred.
- rstn asserted at SCLK edge 8 of a WRITE reg 2 -> cipo=0 immediately; after release, READ 2 (2 frames later) returns 16'h0000.
- With INTAN_EMU_DDR_EN: READ 63, CHIP_ID=8'h12 -> 32 sampled bits de-interleave to A=16'h0012, B=16'h8012.
